// File: rtl/mips_hilo_sequencer.sv
// HI/LO unit controller for the EX stage. It runs MULT/MULTU/DIV/DIVU one bit per
// cycle, handles MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while an operation
// is in flight.
//
// state | meaning
// IDLE  | no operation in flight; MT*/MF* are serviced
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
module mips_hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic             flush,
    input  logic [6:0]       opFunc,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] readData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    // Tag bit 6 set marks a func-sourced (R-format) tag.
    localparam logic SRC_FUNC = 1'b1;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem, dvd, dvsr, rs_hold;
    logic                 neg_res, neg_rem, div_zero;

    logic                 src_func, is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic                 is_mul, is_div, is_signed, recognised, accept, last_step;
    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;

    logic [2*WIDTH-1:0]   acc_step, prod_fix;
    logic [WIDTH:0]       rem_shift, rem_diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_step, dvd_step, quo_fix, rem_fix;

    assign src_func   = (opFunc[6] == SRC_FUNC);
    assign is_mfhi    = src_func && (opFunc[5:0] == F_MFHI);
    assign is_mthi    = src_func && (opFunc[5:0] == F_MTHI);
    assign is_mflo    = src_func && (opFunc[5:0] == F_MFLO);
    assign is_mtlo    = src_func && (opFunc[5:0] == F_MTLO);
    assign is_mul     = src_func && (opFunc[5:0] == F_MULT || opFunc[5:0] == F_MULTU);
    assign is_div     = src_func && (opFunc[5:0] == F_DIV  || opFunc[5:0] == F_DIVU);
    assign is_signed  = src_func && (opFunc[5:0] == F_MULT || opFunc[5:0] == F_DIV);
    assign recognised = is_mfhi | is_mthi | is_mflo | is_mtlo | is_mul | is_div;

    assign busy      = (state != IDLE);
    assign stall     = issue & recognised & busy & ~flush;
    assign accept    = issue & (is_mul | is_div) & (state == IDLE) & ~flush;
    assign last_step = (cnt == LAST_STEP);
    assign readData  = (issue && !busy && is_mfhi) ? hi :
                       (issue && !busy && is_mflo) ? lo : '0;

    // Signed variants operate on magnitudes; the sign is reapplied at completion.
    assign rs_neg = is_signed & rs[WIDTH-1];
    assign rt_neg = is_signed & rt[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs + WIDTH'(1)) : rs;
    assign rt_mag = rt_neg ? (~rt + WIDTH'(1)) : rt;

    // One multiply step and one restoring divide step, plus sign-corrected results.
    assign acc_step  = acc + (mplier[0] ? mcand : '0);
    assign prod_fix  = neg_res ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvsr};
    assign q_bit     = ~rem_diff[WIDTH];
    assign rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign dvd_step  = {dvd[WIDTH-2:0], q_bit};
    assign quo_fix   = neg_res ? (~dvd_step + WIDTH'(1)) : dvd_step;
    assign rem_fix   = neg_rem ? (~rem_step + WIDTH'(1)) : rem_step;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: start on accept, finish on the last step; flush overrides all.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_mul ? MUL : DIV;
            MUL,
            DIV:     if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand capture, iteration datapath and HI/LO writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvsr     <= '0;
            rs_hold  <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                cnt      <= '0;
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, rs_mag};
                mplier   <= rt_mag;
                rem      <= '0;
                dvd      <= rs_mag;
                dvsr     <= rt_mag;
                rs_hold  <= rs;
                neg_res  <= rs_neg ^ rt_neg;
                neg_rem  <= rs_neg;
                div_zero <= (rt == '0);
            end else if (issue && !flush && is_mthi) begin
                hi <= rs;
            end else if (issue && !flush && is_mtlo) begin
                lo <= rs;
            end
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= last_step ? '0 : cnt + CW'(1);
            if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (last_step) {hi, lo} <= prod_fix;
            end else begin
                rem <= rem_step;
                dvd <= dvd_step;
                if (last_step) begin
                    // Divide by zero has a fixed architectural result.
                    if (div_zero) begin
                        lo <= '1;
                        hi <= rs_hold;
                    end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
                end
            end
        end
    end
endmodule

// File: doc/mips_hilo_sequencer.md
Name: mips_hilo_sequencer

Overview:
- Multi-cycle HI/LO unit controller in the EX stage of the pipelined MIPS core.
- Consumes the decoded 7-bit opFunc tag produced by instruction decode: source bit plus op/func code.
- Sequences iterative multiply and divide over the HI/LO register pair.
- Raises a stall to hold the pipeline when a HI/LO consumer or a new HI/LO operation meets an operation still in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width; iteration count equals WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue  input  1  valid instruction present in EX this cycle.
- flush  input  1  cancel any in-flight operation (branch/exception squash).
- opFunc  input  7  decoded OpFunc tag: Source_Func tag concatenated with the R-format func field.
- rs  input  WIDTH  first operand (multiplicand / dividend / MTHI/MTLO data).
- rt  input  WIDTH  second operand (multiplier / divisor).
- stall  output  1  hold EX and upstream stages; combinational.
- busy  output  1  an operation is in flight.
- readData  output  WIDTH  HI for MFHI, LO for MFLO; 0 otherwise.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Recognised codes (func-sourced only): MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- Any op-sourced tag or other func code is ignored.
- Reset (async): state IDLE, hi=lo=0, busy=0, iteration counter=0. stall and readData follow combinationally from busy=0.
- States:
  - IDLE: busy=0.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
- Accept rule: issue & MULT/MULTU/DIV/DIVU & state==IDLE & !flush.
  - Latch operand magnitudes (signed variants take absolute values) and result sign flags.
  - Clear the counter and enter MUL or DIV.
- Iteration: one step per edge; counter runs 0..WIDTH-1.
  - On the edge where the counter equals WIDTH-1, write hi/lo (sign-corrected) and return to IDLE.
  - Latency: if accepted at edge E, hi/lo are updated at edge E+WIDTH (E+32).
  - busy is high for exactly 32 cycles.
- Multiply results: hi:lo = 64-bit product; signed result negated when the operand signs differ.
- Divide results: lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
- Divide by zero: lo=all ones, hi=rs. Timing is unchanged at 32 cycles. Same for DIV and DIVU.
- Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0.
- MTHI/MTLO: in IDLE, write hi/lo with rs on the next edge.
- MFHI/MFLO: in IDLE, readData = hi/lo combinationally.
- stall = issue & recognised code & busy & !flush.
  - A stalled instruction is not accepted; it is re-presented while stall holds.
- Completion cycle: during the final iteration cycle busy is still 1, so a waiting MFLO stalls. It reads the new value in the following cycle.
- flush: in any state, return to IDLE on the next edge; hi/lo unchanged; counter cleared. flush in the same cycle as an accept-eligible issue: flush wins, nothing starts.
- reset mid-operation: immediate IDLE, hi=lo=0.
- Arithmetic uses a WIDTH+1-bit remainder for restoring subtract and a 2·WIDTH-bit product accumulator. No multi-bit-per-cycle shortcuts.

Test Plan:
- Reset asserted mid-MUL at iteration 10 -> busy=0, hi=lo=0 immediately; stall=0 after release.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=-3, rt=7, then MFLO issued the next cycle -> stall high 32 cycles, then readData=0xFFFFFFEB, hi=0xFFFFFFFF.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. A back-to-back DIVU issued while busy stalls and is accepted on the cycle after completion.
- MULT started, flush at iteration 5 -> IDLE next edge, hi/lo keep their prior MTHI/MTLO values (0x1234, 0x5678). flush together with a MULT issue -> no start, busy stays 0.
